// File: rtl/hdmi_src_sched.sv
// rtl/hdmi_src_sched.sv - frame-aligned scheduler sharing one video encoder between several AXI-stream sources
module hdmi_src_sched #(
    parameter int NUM_SRC  = 2,
    parameter int SEL_W    = 1,
    parameter int BPP      = 24,
    parameter int SYNC_TMO = 2**22,
    parameter int CNT_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [NUM_SRC-1:0]     s_axis_tvalid_i,
    output logic [NUM_SRC-1:0]     s_axis_tready_o,
    input  logic [NUM_SRC*BPP-1:0] s_axis_tdata_i,
    input  logic [NUM_SRC-1:0]     s_axis_tuser_i,
    output logic                   m_axis_tvalid_o,
    input  logic                   m_axis_tready_i,
    output logic [BPP-1:0]         m_axis_tdata_o,
    output logic                   m_axis_tuser_o,
    output logic [SEL_W-1:0]       cur_sel_o,
    output logic                   locked_o,
    output logic                   sync_err_o,
    output logic [CNT_W-1:0]       frame_cnt_o
);

    localparam int TMO_W = $clog2(SYNC_TMO);

    typedef enum logic {SYNC, STREAM} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] tgt, cur, idx;
    logic             pend;
    logic [TMO_W-1:0] tmo_cnt;
    logic [BPP-1:0]   src_data [NUM_SRC];
    logic             sel_ok, sof, sw, fwd_sof;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign src_data[k] = s_axis_tdata_i[k*BPP +: BPP];
    end

    assign sel_ok  = ({1'b0, sel_i} < (SEL_W+1)'(NUM_SRC));
    // In SYNC the mux already points at the target so its SOF can be held and then forwarded.
    assign idx     = (state == SYNC) ? tgt : cur;
    assign sof     = s_axis_tvalid_i[idx] & s_axis_tuser_i[idx];
    assign sw      = (state == STREAM) & pend & sof;
    assign fwd_sof = (state == STREAM) & ~sw & sof & m_axis_tready_i;

    assign m_axis_tdata_o = src_data[idx];
    assign m_axis_tuser_o = s_axis_tuser_i[idx];
    assign cur_sel_o      = idx;
    assign locked_o       = (state == STREAM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= SYNC;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        m_axis_tvalid_o = 1'b0;
        s_axis_tready_o = '1;
        case (state)
            SYNC: begin
                s_axis_tready_o[idx] = ~sof;
                if (sof) state_nxt = STREAM;
            end
            STREAM: begin
                m_axis_tvalid_o      = s_axis_tvalid_i[idx] & ~sw;
                s_axis_tready_o[idx] = m_axis_tready_i & ~sw;
                if (sw) state_nxt = SYNC;
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tgt         <= '0;
            cur         <= '0;
            pend        <= 1'b0;
            tmo_cnt     <= '0;
            sync_err_o  <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            if (fwd_sof) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            case (state)
                SYNC: begin
                    if (sof) begin
                        cur     <= tgt;
                        tmo_cnt <= '0;
                        // A request arriving on the lock cycle becomes a pending switch.
                        if (sel_ok) begin
                            tgt  <= sel_i;
                            pend <= (sel_i != tgt);
                        end
                    end else if (sel_ok && sel_i != tgt) begin
                        tgt     <= sel_i;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != TMO_W'(SYNC_TMO-1)) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt == TMO_W'(SYNC_TMO-2)) sync_err_o <= 1'b1;
                    end
                end
                STREAM: begin
                    if (sw) begin
                        cur     <= tgt;
                        pend    <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (sel_ok) begin
                        tgt  <= sel_i;
                        pend <= (sel_i != cur);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_src_sched.sv
// tb/tb_hdmi_src_sched.sv - directed bench for hdmi_src_sched
module tb_hdmi_src_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  sel;
    logic [1:0]  sv, su, sr;
    logic [47:0] sd;
    logic        mv, mr, mu;
    logic [23:0] md;
    logic [0:0]  cur;
    logic        lk, err;
    logic [15:0] fc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          px, rx;

    always #5 clk = ~clk;

    hdmi_src_sched #(
        .NUM_SRC(2), .SEL_W(1), .BPP(24), .SYNC_TMO(64), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel),
        .s_axis_tvalid_i(sv), .s_axis_tready_o(sr), .s_axis_tdata_i(sd), .s_axis_tuser_i(su),
        .m_axis_tvalid_o(mv), .m_axis_tready_i(mr), .m_axis_tdata_o(md), .m_axis_tuser_o(mu),
        .cur_sel_o(cur), .locked_o(lk), .sync_err_o(err), .frame_cnt_o(fc)
    );

    task automatic chk(input string tag, input logic ok, input logic [63:0] obs);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $error("FAIL %s: observed %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] u,
                         input logic [23:0] d0, input logic [23:0] d1);
        sv = v;
        su = u;
        sd = {d1, d0};
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; sv = '0; su = '0; sd = '0; mr = 1'b1;
        #2;
        chk("rst_tvalid", mv === 1'b0, mv);
        chk("rst_cur", cur === 1'b0, cur);
        chk("rst_locked", lk === 1'b0, lk);
        chk("rst_err", err === 1'b0, err);
        chk("rst_fcnt", fc === 16'd0, fc);
        chk("rst_tready", sr === 2'b11, sr);
        #10 rst_n = 1'b1;
        tick();

        drive(2'b01, 2'b00, 24'hA00001, 24'h0);
        chk("t1_drop_rdy", sr === 2'b11, sr);
        chk("t1_drop_vld", mv === 1'b0, mv);
        tick();
        drive(2'b01, 2'b00, 24'hA00002, 24'h0); tick();
        drive(2'b01, 2'b00, 24'hA00003, 24'h0);
        chk("t1_unlocked", lk === 1'b0, lk);
        tick();
        drive(2'b01, 2'b01, 24'hF00000, 24'h0);
        chk("t1_sof_hold", sr === 2'b10, sr);
        chk("t1_sof_vld", mv === 1'b0, mv);
        tick();
        chk("t1_locked", lk === 1'b1, lk);
        chk("t1_fwd_vld", mv === 1'b1, mv);
        chk("t1_fwd_user", mu === 1'b1, mu);
        chk("t1_fwd_data", md === 24'hF00000, md);
        chk("t1_fcnt0", fc === 16'd0, fc);
        tick();
        drive(2'b01, 2'b00, 24'hB00001, 24'h0);
        chk("t1_fcnt1", fc === 16'd1, fc);
        chk("t1_mid_data", md === 24'hB00001, md);
        chk("t1_mid_user", mu === 1'b0, mu);
        tick();

        sel = 1'b1;
        drive(2'b01, 2'b00, 24'hB00002, 24'h0);
        chk("t2_pass_vld", mv === 1'b1, mv);
        chk("t2_pass_data", md === 24'hB00002, md);
        tick();
        drive(2'b11, 2'b00, 24'hB00003, 24'hC00001);
        chk("t2_pend_vld", mv === 1'b1, mv);
        chk("t2_pend_data", md === 24'hB00003, md);
        chk("t2_pend_rdy", sr === 2'b11, sr);
        tick();
        drive(2'b11, 2'b01, 24'hF00001, 24'hC00001);
        chk("t2_sw_vld", mv === 1'b0, mv);
        chk("t2_sw_rdy", sr === 2'b10, sr);
        chk("t2_sw_cur", cur === 1'b0, cur);
        tick();
        drive(2'b11, 2'b01, 24'hF00001, 24'hC00002);
        chk("t2_sync_cur", cur === 1'b1, cur);
        chk("t2_sync_lk", lk === 1'b0, lk);
        chk("t2_sync_vld", mv === 1'b0, mv);
        chk("t2_sync_rdy", sr === 2'b11, sr);
        tick();
        drive(2'b10, 2'b10, 24'h0, 24'hF00002);
        chk("t2_sof1_rdy", sr === 2'b01, sr);
        chk("t2_sof1_vld", mv === 1'b0, mv);
        tick();
        chk("t2_lk1", lk === 1'b1, lk);
        chk("t2_first_vld", mv === 1'b1, mv);
        chk("t2_first_data", md === 24'hF00002, md);
        chk("t2_first_user", mu === 1'b1, mu);
        chk("t2_cur1", cur === 1'b1, cur);
        tick();

        sel = 1'b0;
        drive(2'b10, 2'b00, 24'h0, 24'hC00003);
        chk("t3_fcnt2", fc === 16'd2, fc);
        chk("t3_c3_data", md === 24'hC00003, md);
        tick();
        drive(2'b10, 2'b10, 24'h0, 24'hF00003);
        chk("t3_sw_vld", mv === 1'b0, mv);
        chk("t3_sw_rdy", sr === 2'b01, sr);
        tick();
        drive(2'b01, 2'b01, 24'h0, 24'h0);
        chk("t3_sync_cur", cur === 1'b0, cur);
        chk("t3_sync_lk", lk === 1'b0, lk);
        chk("t3_sync_rdy", sr === 2'b10, sr);
        tick();

        px = 0;
        rx = 0;
        for (int c = 0; c < 4096 && rx < 1024; c++) begin
            mr = c[0];
            drive({1'b0, px < 1024}, {1'b0, (px % 256) == 0}, 24'(px), 24'h0);
            if (mv && mr) begin
                chk("t3_scoreboard", {mu, md} === {(rx % 256) == 0, 24'(rx)}, {mu, md});
                rx++;
            end
            if (sv[0] && sr[0]) px++;
            tick();
        end
        mr = 1'b1;
        chk("t3_rx_count", rx === 1024, rx);
        chk("t3_tx_count", px === 1024, px);
        chk("t3_fcnt6", fc === 16'd6, fc);

        sel = 1'b1;
        drive(2'b01, 2'b00, 24'hD00001, 24'h0); tick();
        sel = 1'b0;
        drive(2'b01, 2'b00, 24'hD00002, 24'h0); tick();
        drive(2'b01, 2'b01, 24'hF00005, 24'h0);
        chk("t4_sof_vld", mv === 1'b1, mv);
        chk("t4_sof_user", mu === 1'b1, mu);
        chk("t4_lk", lk === 1'b1, lk);
        tick();
        drive(2'b01, 2'b00, 24'hD00003, 24'h0);
        chk("t4_fcnt7", fc === 16'd7, fc);
        chk("t4_cur0", cur === 1'b0, cur);
        tick();
        drive(2'b01, 2'b01, 24'hF00006, 24'h0);
        chk("t4_sof2_vld", mv === 1'b1, mv);
        tick();
        drive(2'b01, 2'b00, 24'hD00004, 24'h0);
        chk("t4_fcnt8", fc === 16'd8, fc);
        tick();

        sel = 1'b1;
        drive(2'b11, 2'b00, 24'hD00005, 24'hE00000); tick();
        drive(2'b11, 2'b01, 24'hF00007, 24'hE00001);
        chk("t5_sw_vld", mv === 1'b0, mv);
        tick();
        for (int i = 1; i <= 63; i++) begin
            drive(2'b11, 2'b01, 24'hF00007, 24'(i));
            if (i == 1) chk("t5_cur1", cur === 1'b1, cur);
            chk("t5_no_err", err === 1'b0, err);
            chk("t5_rdy", sr === 2'b11, sr);
            tick();
        end
        drive(2'b11, 2'b01, 24'hF00007, 24'hE00002);
        chk("t5_err_set", err === 1'b1, err);
        chk("t5_err_rdy", sr === 2'b11, sr);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_err_sticky", err === 1'b1, err);
        chk("t5_still_sync", lk === 1'b0, lk);
        chk("t5_cur_tgt", cur === 1'b1, cur);
        chk("t5_fcnt8", fc === 16'd8, fc);

        drive(2'b11, 2'b10, 24'hF00007, 24'hF00008);
        chk("t6_sof_rdy", sr === 2'b01, sr);
        tick();
        chk("t6_lk", lk === 1'b1, lk);
        chk("t6_data", md === 24'hF00008, md);
        tick();
        drive(2'b10, 2'b00, 24'h0, 24'hE00003);
        chk("t6_fcnt9", fc === 16'd9, fc);
        chk("t6_mid_vld", mv === 1'b1, mv);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", mv === 1'b0, mv);
        chk("t6_rst_lk", lk === 1'b0, lk);
        chk("t6_rst_cur", cur === 1'b0, cur);
        chk("t6_rst_err", err === 1'b0, err);
        chk("t6_rst_fcnt", fc === 16'd0, fc);
        chk("t6_rst_rdy", sr === 2'b11, sr);
        #3 rst_n = 1'b1;
        tick();
        chk("t6_retgt", cur === 1'b1, cur);
        chk("t6_relk0", lk === 1'b0, lk);
        drive(2'b10, 2'b10, 24'h0, 24'hF00009);
        chk("t6_resof_rdy", sr === 2'b01, sr);
        chk("t6_resof_vld", mv === 1'b0, mv);
        tick();
        chk("t6_relk1", lk === 1'b1, lk);
        chk("t6_re_data", md === 24'hF00009, md);
        chk("t6_re_user", mu === 1'b1, mu);
        tick();
        chk("t6_re_fcnt", fc === 16'd1, fc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
